// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: data width, register-address width and
// the state encoding of the branch redirect controller.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  // Redirect controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump/trap redirect controller. Takes resolved control transfers from
// EX and trap requests, offers the new PC to IF with a valid/ready handshake,
// flushes the younger pipeline stages, writes back link values and reports
// misaligned jump targets.
//
// Handshake: the controller holds redirect_valid=1 and a stable redirect_pc
// until a cycle in which fetch_ready=1; the redirect is accepted on that
// rising edge. A trap arriving while a redirect is pending replaces the
// offered PC on the next edge, but an acceptance in that same cycle counts.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = rv_pkg::XLEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  input  logic                    ex_taken,
  input  logic [XLEN-1:0]         ex_target,
  input  logic [XLEN-1:0]         ex_link,
  input  logic                    ex_link_en,
  input  logic [rv_pkg::REG_W-1:0] ex_rd,
  input  logic                    trap_req,
  input  logic [XLEN-1:0]         trap_vec,
  input  logic                    fetch_ready,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic                    flush_if,
  output logic                    flush_id,
  output logic                    stall_ex,
  output logic                    wb_link_valid,
  output logic [rv_pkg::REG_W-1:0] wb_link_rd,
  output logic [XLEN-1:0]         wb_link_data,
  output logic                    misalign_exc,
  output logic [XLEN-1:0]         misalign_addr,
  output logic [15:0]             redirect_count,
  output rv_pkg::state_t          dbg_state
);

  import rv_pkg::*;

  // FLUSH_CYCLES is at most 7, so three bits hold the remaining flush count.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [2:0] flush_cnt;

  // A link write happens for JAL/JALR unless the destination is x0.
  logic link_wr;
  // Jump targets must be word aligned (no compressed instructions).
  logic misaligned;

  // Decode the EX request qualifiers.
  always_comb begin
    link_wr    = ex_link_en && (ex_rd != '0);
    misaligned = (ex_target[1:0] != 2'b00);
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      stall_ex       <= 1'b0;
      wb_link_valid  <= 1'b0;
      wb_link_rd     <= '0;
      wb_link_data   <= '0;
      misalign_exc   <= 1'b0;
      misalign_addr  <= '0;
      redirect_count <= '0;
    end else begin
      // Single-cycle pulses default low.
      wb_link_valid <= 1'b0;
      misalign_exc  <= 1'b0;

      case (state)
        IDLE: begin
          if (trap_req) begin
            // Trap wins; the EX instruction is dropped with no link write.
            redirect_pc    <= trap_vec;
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            flush_if       <= 1'b1;
            flush_id       <= 1'b1;
            stall_ex       <= 1'b1;
          end else if (ex_valid && ex_taken && misaligned) begin
            misalign_exc  <= 1'b1;
            misalign_addr <= ex_target;
          end else if (ex_valid && ex_taken) begin
            redirect_pc    <= ex_target;
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            flush_if       <= 1'b1;
            flush_id       <= 1'b1;
            stall_ex       <= 1'b1;
            if (link_wr) begin
              wb_link_valid <= 1'b1;
              wb_link_rd    <= ex_rd;
              wb_link_data  <= ex_link;
            end
          end else if (ex_valid && link_wr) begin
            // Not-taken transfer still writes its link register.
            wb_link_valid <= 1'b1;
            wb_link_rd    <= ex_rd;
            wb_link_data  <= ex_link;
          end
        end

        REDIRECT: begin
          if (fetch_ready) begin
            redirect_count <= redirect_count + 16'd1;
          end
          if (trap_req) begin
            // Stay in REDIRECT offering the trap vector instead.
            redirect_pc <= trap_vec;
          end else if (fetch_ready) begin
            state          <= FLUSH;
            flush_cnt      <= FLUSH_LOAD;
            redirect_valid <= 1'b0;
            flush_if       <= 1'b0;
          end
        end

        FLUSH: begin
          if (trap_req) begin
            redirect_pc    <= trap_vec;
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            flush_if       <= 1'b1;
          end else if (flush_cnt == 3'd0) begin
            state    <= IDLE;
            flush_id <= 1'b0;
            stall_ex <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end

        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush_if       <= 1'b0;
          flush_id       <= 1'b0;
          stall_ex       <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl. Stimulus pushes expected
// redirect, link and misalign events into queues; a negedge monitor pops
// and compares whenever the DUT presents one of those outputs.
module tb_branch_redirect_ctrl;
  import rv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_link;
  logic        ex_link_en;
  logic [4:0]  ex_rd;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic        stall_ex;
  logic        wb_link_valid;
  logic [4:0]  wb_link_rd;
  logic [31:0] wb_link_data;
  logic        misalign_exc;
  logic [31:0] misalign_addr;
  logic [15:0] redirect_count;
  state_t      dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // {count before acceptance, pc}
  logic [47:0] exp_redir_q[$];
  // {rd, data}
  logic [36:0] exp_link_q[$];
  logic [31:0] exp_mis_q[$];

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_link(ex_link), .ex_link_en(ex_link_en), .ex_rd(ex_rd),
    .trap_req(trap_req), .trap_vec(trap_vec), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .stall_ex(stall_ex),
    .wb_link_valid(wb_link_valid), .wb_link_rd(wb_link_rd),
    .wb_link_data(wb_link_data), .misalign_exc(misalign_exc),
    .misalign_addr(misalign_addr), .redirect_count(redirect_count),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid   = 1'b0;
    ex_taken   = 1'b0;
    ex_target  = '0;
    ex_link    = '0;
    ex_link_en = 1'b0;
    ex_rd      = '0;
    trap_req   = 1'b0;
    trap_vec   = '0;
  endtask

  task automatic drive_ex(input logic taken, input logic [31:0] target,
                          input logic [31:0] link, input logic link_en,
                          input logic [4:0] rd);
    ex_valid   = 1'b1;
    ex_taken   = taken;
    ex_target  = target;
    ex_link    = link;
    ex_link_en = link_en;
    ex_rd      = rd;
  endtask

  // Wait (bounded) until the controller releases EX.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (stall_ex && n < 40) begin
      tick();
      n++;
    end
    if (stall_ex) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: stall_ex still 1 after 40 cycles, expected 0", name);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect_valid && fetch_ready) begin
        if (exp_redir_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL redir_unexp: pc 0x%0h accepted, expected none", redirect_pc);
        end else begin
          logic [47:0] e;
          e = exp_redir_q.pop_front();
          chk("redir_pc", {16'd0, redirect_pc}, {16'd0, e[31:0]});
          chk("redir_cnt", {32'd0, redirect_count}, {32'd0, e[47:32]});
        end
      end
      if (wb_link_valid) begin
        if (exp_link_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL link_unexp: rd %0d data 0x%0h, expected none", wb_link_rd, wb_link_data);
        end else begin
          logic [36:0] l;
          l = exp_link_q.pop_front();
          chk("link", {11'd0, wb_link_rd, wb_link_data}, {11'd0, l});
        end
      end
      if (misalign_exc) begin
        if (exp_mis_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL mis_unexp: addr 0x%0h, expected none", misalign_addr);
        end else begin
          logic [31:0] m;
          m = exp_mis_q.pop_front();
          chk("mis_addr", {16'd0, misalign_addr}, {16'd0, m});
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int n;
    idle_inputs();
    fetch_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {47'd0, redirect_valid}, 48'd0);
    chk("rst_pc", {16'd0, redirect_pc}, 48'd0);
    chk("rst_flush", {46'd0, flush_if, flush_id}, 48'd0);
    chk("rst_cnt", {32'd0, redirect_count}, 48'd0);
    rst_n = 1'b1;
    tick();

    // JAL pc=0x1000 imm=0x100, rd=1
    fetch_ready = 1'b1;
    drive_ex(1'b1, 32'h1100, 32'h1004, 1'b1, 5'd1);
    exp_redir_q.push_back({16'd0, 32'h1100});
    exp_link_q.push_back({5'd1, 32'h1004});
    tick();
    idle_inputs();
    chk("jal_valid", {47'd0, redirect_valid}, 48'd1);
    chk("jal_pc", {16'd0, redirect_pc}, {16'd0, 32'h1100});
    n = 0;
    while (flush_id && n < 20) begin
      n++;
      tick();
    end
    chk("jal_flush_len", 48'(n), 48'd3);
    chk("jal_cnt", {32'd0, redirect_count}, 48'd1);

    // Target 0x0FFC held while fetch is not ready
    fetch_ready = 1'b0;
    drive_ex(1'b1, 32'h0FFC, 32'h0, 1'b0, 5'd0);
    exp_redir_q.push_back({16'd1, 32'h0FFC});
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("hold_pc", {15'd0, redirect_valid, redirect_pc}, {15'd0, 1'b1, 32'h0FFC});
      tick();
    end
    fetch_ready = 1'b1;
    chk("hold_pc4", {15'd0, redirect_valid, redirect_pc}, {15'd0, 1'b1, 32'h0FFC});
    tick();
    chk("hold_flush", {46'd0, redirect_valid, flush_id}, 48'd1);
    wait_idle("hold_idle");
    chk("hold_cnt", {32'd0, redirect_count}, 48'd2);

    // Misaligned taken target
    drive_ex(1'b1, 32'h1102, 32'h1008, 1'b1, 5'd5);
    exp_mis_q.push_back(32'h1102);
    tick();
    idle_inputs();
    chk("mis_pulse", {45'd0, misalign_exc, redirect_valid, wb_link_valid}, 48'b100);
    tick();
    chk("mis_held", {15'd0, misalign_exc, misalign_addr}, {15'd0, 1'b0, 32'h1102});

    // Not-taken transfer with a link write
    drive_ex(1'b0, 32'h9000, 32'h2008, 1'b1, 5'd3);
    exp_link_q.push_back({5'd3, 32'h2008});
    tick();
    idle_inputs();
    chk("nt_noredir", {47'd0, redirect_valid}, 48'd0);
    tick();

    // Trap during FLUSH
    drive_ex(1'b1, 32'h3000, 32'h0, 1'b0, 5'd0);
    exp_redir_q.push_back({16'd2, 32'h3000});
    tick();
    idle_inputs();
    tick();
    chk("trapf_in_flush", {46'd0, redirect_valid, flush_id}, 48'd1);
    trap_req = 1'b1;
    trap_vec = 32'h0000_0100;
    exp_redir_q.push_back({16'd3, 32'h0000_0100});
    tick();
    idle_inputs();
    chk("trapf_pc", {15'd0, redirect_valid, redirect_pc}, {15'd0, 1'b1, 32'h100});
    chk("trapf_cnt", {32'd0, redirect_count}, 48'd3);
    tick();
    wait_idle("trapf_idle");
    chk("trapf_cnt2", {32'd0, redirect_count}, 48'd4);

    // Trap in REDIRECT coincident with acceptance
    drive_ex(1'b1, 32'h4000, 32'h0, 1'b0, 5'd0);
    exp_redir_q.push_back({16'd4, 32'h4000});
    tick();
    idle_inputs();
    trap_req = 1'b1;
    trap_vec = 32'h0000_0200;
    exp_redir_q.push_back({16'd5, 32'h0000_0200});
    tick();
    idle_inputs();
    chk("trapr_pc", {15'd0, redirect_valid, redirect_pc}, {15'd0, 1'b1, 32'h200});
    chk("trapr_cnt", {32'd0, redirect_count}, 48'd5);
    tick();
    wait_idle("trapr_idle");
    chk("trapr_cnt2", {32'd0, redirect_count}, 48'd6);

    // JAL rd=0 to address 0 (wrapped target): no link write
    drive_ex(1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1, 5'd0);
    exp_redir_q.push_back({16'd6, 32'h0});
    tick();
    idle_inputs();
    chk("x0_link", {47'd0, wb_link_valid}, 48'd0);
    chk("x0_valid", {47'd0, redirect_valid}, 48'd1);
    wait_idle("x0_idle");

    // Trap has priority over a taken EX jump with link in IDLE
    drive_ex(1'b1, 32'h600, 32'h404, 1'b1, 5'd2);
    trap_req = 1'b1;
    trap_vec = 32'h500;
    exp_redir_q.push_back({16'd7, 32'h500});
    tick();
    idle_inputs();
    chk("prio_pc", {16'd0, redirect_pc}, {16'd0, 32'h500});
    wait_idle("prio_idle");
    chk("prio_cnt", {32'd0, redirect_count}, 48'd8);

    // Reset in the middle of a pending redirect
    fetch_ready = 1'b0;
    drive_ex(1'b1, 32'h7000, 32'h0, 1'b0, 5'd0);
    tick();
    idle_inputs();
    chk("rstm_pending", {47'd0, redirect_valid}, 48'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_out", {44'd0, redirect_valid, flush_if, flush_id, stall_ex}, 48'd0);
    chk("rstm_pc", {16'd0, redirect_pc}, 48'd0);
    chk("rstm_cnt", {16'd0, misalign_addr}, {32'd0, redirect_count});
    chk("rstm_cnt0", {32'd0, redirect_count}, 48'd0);
    tick();
    fetch_ready = 1'b1;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rstm_novalid", {47'd0, redirect_valid}, 48'd0);
    chk("rstm_state", {46'd0, dbg_state}, {46'd0, IDLE});
    chk("rstm_cnt_after", {32'd0, redirect_count}, 48'd0);

    // All expected events observed
    chk("q_redir", 48'(exp_redir_q.size()), 48'd0);
    chk("q_link", 48'(exp_link_q.size()), 48'd0);
    chk("q_mis", 48'(exp_mis_q.size()), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
